// File: rtl/hop_pkg.sv
// ============================================================================
// hop_pkg : shared helpers for the hop chain pipeline (group mapping,
//           occupancy width, saturating increment).   Rev 1.0
// ============================================================================
`default_nettype none

package hop_pkg;

    localparam int c_MAX_CNT_W = 32;

    // Stages past the last full group fold into the final group.
    function automatic int grp_of(input int stage, input int per_grp, input int num_grp);
        int g;
        g = stage / per_grp;
        return (g > num_grp - 1) ? num_grp - 1 : g;
    endfunction

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [c_MAX_CNT_W-1:0] sat_inc(input logic [c_MAX_CNT_W-1:0] val,
                                                      input int                     width);
        logic [c_MAX_CNT_W-1:0] max_val;
        max_val = (width >= c_MAX_CNT_W) ? '1 : ((c_MAX_CNT_W'(1) << width) - c_MAX_CNT_W'(1));
        return (val >= max_val) ? max_val : val + c_MAX_CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/hop_stage.sv
// ============================================================================
// hop_stage : one {valid,data} hop register with async clear and load enable.
//             Rev 1.0
// ============================================================================
`default_nettype none

module hop_stage #(
    parameter int W = 8
) (
    input  logic         clock0,
    input  logic         i_clr,
    input  logic         i_ld,
    input  logic [W:0]   i_d,
    output logic [W:0]   o_q
);

    logic [W:0] r_q;

    always_ff @(posedge clock0 or posedge i_clr) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/hop_chain_pipe.sv
// ============================================================================
// hop_chain_pipe : DEPTH-stage valid/data pipeline with group resets, gated
//                  tail, occupancy popcount and saturating drop counter. Rev 1.0
// ============================================================================
`default_nettype none

module hop_chain_pipe
    import hop_pkg::*;
#(
    parameter int W              = 8,
    parameter int DEPTH          = 8,
    parameter int EN_FROM        = 7,
    parameter int NUM_GRP        = 6,
    parameter int STAGES_PER_GRP = 1,
    parameter int CNT_W          = 8
) (
    input  logic                      clock0,
    input  logic                      rst1,
    input  logic [NUM_GRP-1:0]        rst_grp,
    input  logic                      en,
    input  logic                      in_valid,
    input  logic [W-1:0]              in_data,
    input  logic                      drop_clr,
    output logic                      out_valid,
    output logic [W-1:0]              out_data,
    output logic [occ_w(DEPTH)-1:0]   occupancy,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int c_OCC_W = occ_w(DEPTH);

    logic [DEPTH-1:0]   w_valid;
    logic [W-1:0]       w_data [DEPTH];
    logic               w_drop;
    logic [c_OCC_W-1:0] w_occ;
    logic [CNT_W-1:0]   r_drop_cnt;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        localparam int   c_GRP   = grp_of(i, STAGES_PER_GRP, NUM_GRP);
        localparam logic c_GATED = (i >= EN_FROM);

        logic [W:0] w_d;
        logic [W:0] w_q;
        logic       w_ld;
        logic       w_clr;

        if (i == 0) begin : g_head
            assign w_d = {in_valid, in_data};
        end else begin : g_body
            assign w_d = {w_valid[i-1], w_data[i-1]};
        end

        assign w_ld  = ~c_GATED | en;
        assign w_clr = rst1 | rst_grp[c_GRP];

        hop_stage #(
            .W (W)
        ) u_stage (
            .clock0 (clock0),
            .i_clr  (w_clr),
            .i_ld   (w_ld),
            .i_d    (w_d),
            .o_q    (w_q)
        );

        assign w_valid[i] = w_q[W];
        assign w_data[i]  = w_q[W-1:0];
    end

    // The last ungated stage is overwritten while the gated tail stalls.
    if (EN_FROM > 0 && EN_FROM < DEPTH) begin : g_drop
        assign w_drop = ~en & w_valid[EN_FROM-1];
    end else begin : g_no_drop
        assign w_drop = 1'b0;
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_drop_cnt <= '0;
        end else if (drop_clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= CNT_W'(sat_inc(c_MAX_CNT_W'(r_drop_cnt), CNT_W));
        end
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + c_OCC_W'(w_valid[i]);
        end
    end

    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = w_occ;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hop_chain_pipe.sv
// ============================================================================
// tb_hop_chain_pipe : directed + random bench for hop_chain_pipe against an
//                     array-based behavioural model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_hop_chain_pipe;

    localparam int W       = 8;
    localparam int DEPTH   = 8;
    localparam int EN_FROM = 7;
    localparam int NUM_GRP = 6;
    localparam int SPG     = 1;
    localparam int CNT_W   = 8;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                clock0 = 1'b0;
    logic                rst1;
    logic [NUM_GRP-1:0]  rst_grp;
    logic                en;
    logic                in_valid;
    logic [W-1:0]        in_data;
    logic                drop_clr;
    logic                out_valid;
    logic [W-1:0]        out_data;
    logic [OCC_W-1:0]    occupancy;
    logic [CNT_W-1:0]    drop_cnt;

    int errors = 0;
    int checks = 0;

    bit mv [DEPTH];
    int md [DEPTH];
    int mcnt;

    always #5 clock0 = ~clock0;

    hop_chain_pipe #(
        .W              (W),
        .DEPTH          (DEPTH),
        .EN_FROM        (EN_FROM),
        .NUM_GRP        (NUM_GRP),
        .STAGES_PER_GRP (SPG),
        .CNT_W          (CNT_W)
    ) dut (
        .clock0    (clock0),
        .rst1      (rst1),
        .rst_grp   (rst_grp),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .drop_clr  (drop_clr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    function automatic int grp(input int i);
        int g;
        g = i / SPG;
        return (g > NUM_GRP - 1) ? NUM_GRP - 1 : g;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mv[i] = 1'b0;
            md[i] = 0;
        end
        mcnt = 0;
    endtask

    task automatic model_clear_groups();
        for (int i = 0; i < DEPTH; i++) begin
            if (rst_grp[grp(i)]) begin
                mv[i] = 1'b0;
                md[i] = 0;
            end
        end
    endtask

    task automatic model_edge();
        bit drop;
        if (rst1) begin
            model_reset();
            return;
        end
        drop = (EN_FROM > 0) && (EN_FROM < DEPTH) && !en && mv[EN_FROM-1];
        for (int i = DEPTH - 1; i >= 1; i--) begin
            if (i < EN_FROM || en) begin
                mv[i] = mv[i-1];
                md[i] = md[i-1];
            end
        end
        if (EN_FROM != 0 || en) begin
            mv[0] = in_valid;
            md[0] = int'(in_data);
        end
        if (drop_clr)
            mcnt = 0;
        else if (drop && mcnt < CNT_MAX)
            mcnt++;
        model_clear_groups();
    endtask

    task automatic check_outputs(input string tag);
        int occ;
        occ = 0;
        for (int i = 0; i < DEPTH; i++) occ += int'(mv[i]);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(mv[DEPTH-1]));
        if (mv[DEPTH-1]) chk({tag, ".out_data"}, 32'(out_data), md[DEPTH-1]);
        chk({tag, ".occupancy"}, 32'(occupancy), occ);
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), mcnt);
    endtask

    task automatic tick(input string tag);
        @(posedge clock0);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int held;
        rst1     = 1'b1;
        rst_grp  = '0;
        en       = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        drop_clr = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clock0);
        #3;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_data", 32'(out_data), 0);
        chk("rst.occupancy", 32'(occupancy), 0);
        chk("rst.drop_cnt", 32'(drop_cnt), 0);
        rst1 = 1'b0;

        // Single word latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick("lat");
        chk("lat.occ1", 32'(occupancy), 1);
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (7) tick("lat");
        chk("lat.out_valid", 32'(out_valid), 1);
        chk("lat.out_data", 32'(out_data), 32'h A5);
        tick("lat");
        chk("lat.occ0", 32'(occupancy), 0);

        // Stream until full
        in_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            in_data = W'($urandom);
            tick("fill");
        end
        chk("fill.occ", 32'(occupancy), DEPTH);
        for (int k = 0; k < DEPTH; k++) begin
            in_data = W'($urandom);
            tick("stream");
        end

        // Gated tail with continuous input
        held = md[DEPTH-1];
        en   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_data = W'($urandom);
            tick("gate");
        end
        chk("gate.drop5", 32'(drop_cnt), 5);
        chk("gate.held", 32'(out_data), held);

        // Saturation, then clear coinciding with a drop
        for (int k = 0; k < 260; k++) begin
            in_data = W'($urandom);
            tick("sat");
        end
        chk("sat.max", 32'(drop_cnt), CNT_MAX);
        drop_clr = 1'b1;
        tick("clr");
        chk("clr.zero", 32'(drop_cnt), 0);
        drop_clr = 1'b0;

        // Group reset over the boundary stage while stalled is not a drop
        rst_grp = 6'b100000;
        #1;
        model_clear_groups();
        check_outputs("grp5.async");
        tick("grp5");
        rst_grp = '0;
        tick("grp5");
        chk("grp5.nodrop", 32'(drop_cnt), 0);

        // Refill, then single group-reset bubble
        en = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            in_data = W'($urandom);
            tick("refill");
        end
        chk("refill.occ", 32'(occupancy), DEPTH);
        rst_grp = 6'b000100;
        #1;
        model_clear_groups();
        chk("bub.occ7", 32'(occupancy), 7);
        #1;
        rst_grp = '0;
        for (int k = 0; k < 5; k++) begin
            in_data = W'($urandom);
            tick("bub");
        end
        chk("bub.hole", 32'(out_valid), 0);
        tick("bub");
        chk("bub.after", 32'(out_valid), 1);

        // Async global reset with full pipe and four drops
        drop_clr = 1'b1;
        tick("pre");
        drop_clr = 1'b0;
        en       = 1'b0;
        repeat (4) tick("pre");
        chk("pre.drop4", 32'(drop_cnt), 4);
        en = 1'b1;
        #2;
        rst1 = 1'b1;
        #1;
        model_reset();
        chk("arst.out_valid", 32'(out_valid), 0);
        chk("arst.out_data", 32'(out_data), 0);
        chk("arst.occupancy", 32'(occupancy), 0);
        chk("arst.drop_cnt", 32'(drop_cnt), 0);
        tick("arst");
        #3;
        rst1     = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick("post");
        in_valid = 1'b0;
        repeat (7) tick("post");
        chk("post.out_valid", 32'(out_valid), 1);
        chk("post.out_data", 32'(out_data), 32'h3C);

        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            bit hold;
            en       = ($urandom_range(0, 3) != 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = W'($urandom);
            drop_clr = ($urandom_range(0, 15) == 0);
            hold     = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                hold    = $urandom_range(0, 1) == 1;
                rst_grp = NUM_GRP'($urandom);
                #1;
                model_clear_groups();
                check_outputs("rnd.grp");
                if (!hold) rst_grp = '0;
            end
            tick("rnd");
            if (hold) rst_grp = '0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
